led_fill_drain_checker: RTL

// - Observer for the 8-LED fill-then-drain shifter: samples q every clk, tracks fill/drain progress, direction and completed sweeps.
// - Flags illegal steps, stuck patterns and direction mismatch against the commanded lr.
// - Sits beside the shifter in the LED-effect top, and in the bench as a self-checking monitor.

---
 rtl/led_effect_pkg.sv | 22 ++
 rtl/led_fill_drain_checker_if.sv | 31 +++
 rtl/led_fill_drain_checker_next_pattern.sv | 26 ++
 rtl/led_fill_drain_checker.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/led_effect_pkg.sv
// Shared definitions for the LED fill/drain effect blocks.
//   state_t    : checker tracking states (HUNT, LOCKED)
//   err_code_t : error codes reported on err_code
//   DIR_LR/RL  : direction coding shared by lr and dir
package led_effect_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'b00,
      ERR_STEP  = 2'b01,
      ERR_STUCK = 2'b10,
      ERR_DIR   = 2'b11
   } err_code_t;

   localparam logic DIR_LR = 1'b1;
   localparam logic DIR_RL = 1'b0;

endpackage

// File: rtl/led_fill_drain_checker_if.sv
// Observation bus between an LED fill/drain shifter and its checker.
//   master : drives lr (commanded direction) and q (LED pattern), reads status
//   slave  : the checker; reads lr/q, drives locked, dir, draining, level,
//            err, err_code, err_cnt, sweep_cnt
interface led_fill_drain_checker_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned LW = $clog2(WIDTH + 1);

   logic             lr;
   logic [WIDTH-1:0] q;
   logic             locked;
   logic             dir;
   logic             draining;
   logic [LW-1:0]    level;
   logic             err;
   logic [1:0]       err_code;
   logic [7:0]       err_cnt;
   logic [15:0]      sweep_cnt;

   modport master (
      output lr, q,
      input  locked, dir, draining, level, err, err_code, err_cnt, sweep_cnt
   );

   modport slave (
      input  lr, q,
      output locked, dir, draining, level, err, err_code, err_cnt, sweep_cnt
   );

endinterface

// File: rtl/led_fill_drain_checker_next_pattern.sv
// led_next_pattern: combinational shift rule of the fill/drain shifter.
//   cur      in  WIDTH : current LED pattern
//   dir      in  1     : DIR_LR shifts right from the left LED, DIR_RL shifts left
//   draining in  1     : 0 shifts a lit LED in, 1 shifts a dark LED in
//   nxt      out WIDTH : pattern expected on the next step
module led_next_pattern
   import led_effect_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] cur,
   input  logic             dir,
   input  logic             draining,
   output logic [WIDTH-1:0] nxt
);

   always_comb begin
      nxt = '0;
      if (dir == DIR_LR) begin
         nxt = {~draining, cur[WIDTH-1:1]};
      end else begin
         nxt = {cur[WIDTH-2:0], ~draining};
      end
   end

endmodule

// File: rtl/led_fill_drain_checker.sv
// led_fill_drain_checker: observer for the fill-then-drain LED shifter.
// Samples q every clock, locks onto an all-dark pattern, then follows the
// fill/drain sequence, reporting progress, direction and completed sweeps.
//   clk    in : clock, all state on posedge
//   reset  in : synchronous active-high, clears all state
//   bus       : slave modport of led_fill_drain_checker_if
//               (lr, q in; locked, dir, draining, level, err, err_code,
//                err_cnt, sweep_cnt out, all registered)
module led_fill_drain_checker
   import led_effect_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_HOLD = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   led_fill_drain_checker_if.slave  bus
);

   localparam int unsigned LW = $clog2(WIDTH + 1);
   localparam int unsigned HW = $clog2(MAX_HOLD);

   localparam logic [WIDTH-1:0] FIRST_LR  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] FIRST_RL  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [HW-1:0]    HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [LW-1:0]    LVL_ONE   = LW'(1);
   localparam logic [LW-1:0]    LVL_FULL  = LW'(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_prev;
   logic [HW-1:0]    hold_q, hold_d;
   logic             dir_q, dir_d;
   logic             drn_q, drn_d;
   logic [LW-1:0]    lvl_q, lvl_d;
   logic             err_q, err_d;
   err_code_t        code_q, code_d;
   logic [7:0]       ecnt_q, ecnt_d;
   logic [15:0]      scnt_q, scnt_d;

   logic [WIDTH-1:0] exp_next;
   logic             fire;
   err_code_t        kind;
   logic             new_dir;

   // q_prev is always the last accepted pattern while LOCKED, so it is the
   // base for the expected next step.
   led_next_pattern #(
      .WIDTH (WIDTH)
   ) u_next (
      .cur      (q_prev),
      .dir      (dir_q),
      .draining (drn_q),
      .nxt      (exp_next)
   );

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      dir_d   = dir_q;
      drn_d   = drn_q;
      lvl_d   = lvl_q;
      code_d  = code_q;
      ecnt_d  = ecnt_q;
      scnt_d  = scnt_q;
      err_d   = 1'b0;
      fire    = 1'b0;
      kind    = ERR_NONE;
      new_dir = dir_q;

      case (state_q)
         HUNT: begin
            hold_d = '0;
            if (bus.q == '0) begin
               state_d = LOCKED;
               lvl_d   = '0;
               drn_d   = 1'b0;
            end
         end

         LOCKED: begin
            if (bus.q == q_prev) begin
               // hold_cnt sits at MAX_HOLD-1 after that many repeats; one
               // more unchanged sample is the stuck condition.
               if (hold_q == HOLD_LAST) begin
                  fire    = 1'b1;
                  kind    = ERR_STUCK;
                  state_d = HUNT;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end else begin
               hold_d = '0;
               if (lvl_q == '0) begin
                  // Sweep start: the only place the direction may change.
                  if ((bus.q == FIRST_LR) || (bus.q == FIRST_RL)) begin
                     new_dir = (bus.q == FIRST_LR) ? DIR_LR : DIR_RL;
                     dir_d   = new_dir;
                     lvl_d   = LVL_ONE;
                     if (new_dir != bus.lr) begin
                        fire = 1'b1;
                        kind = ERR_DIR;
                     end
                  end else begin
                     fire    = 1'b1;
                     kind    = ERR_STEP;
                     state_d = HUNT;
                  end
               end else if (bus.q == exp_next) begin
                  if (drn_q) begin
                     lvl_d = lvl_q - LVL_ONE;
                     if (lvl_q == LVL_ONE) begin
                        drn_d  = 1'b0;
                        scnt_d = scnt_q + 16'd1;
                     end
                  end else begin
                     lvl_d = lvl_q + LVL_ONE;
                     if (lvl_q == LVL_FULL - LVL_ONE) begin
                        drn_d = 1'b1;
                     end
                  end
               end else begin
                  fire    = 1'b1;
                  kind    = ERR_STEP;
                  state_d = HUNT;
               end
            end
         end

         default: begin
            state_d = HUNT;
         end
      endcase

      if (fire) begin
         err_d  = 1'b1;
         code_d = kind;
         if (ecnt_q != '1) begin
            ecnt_d = ecnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= HUNT;
         q_prev  <= '0;
         hold_q  <= '0;
         dir_q   <= DIR_LR;
         drn_q   <= 1'b0;
         lvl_q   <= '0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
         ecnt_q  <= '0;
         scnt_q  <= '0;
      end else begin
         state_q <= state_d;
         q_prev  <= bus.q;
         hold_q  <= hold_d;
         dir_q   <= dir_d;
         drn_q   <= drn_d;
         lvl_q   <= lvl_d;
         err_q   <= err_d;
         code_q  <= code_d;
         ecnt_q  <= ecnt_d;
         scnt_q  <= scnt_d;
      end
   end

   assign bus.locked    = (state_q == LOCKED);
   assign bus.dir       = dir_q;
   assign bus.draining  = drn_q;
   assign bus.level     = lvl_q;
   assign bus.err       = err_q;
   assign bus.err_code  = code_q;
   assign bus.err_cnt   = ecnt_q;
   assign bus.sweep_cnt = scnt_q;

endmodule
